// File: rtl/am25ls_modcnt.sv
// Programmable-modulus up/down counter with loadable limit, cascade carry-out and registered wrap pulse.
// Latency: q/lim/wrap update on the sampling edge (1 cycle); co is combinational from q/lim/up/t.
// Backpressure: none; p&&t gate counting each edge, load_ and clr take precedence.
// Optional build macro AM25LS_MODCNT_SAT_EN: saturate at the terminal state instead of wrapping (wrap stays 0).
module am25ls_modcnt #(
    parameter int WIDTH = 4
) (
    input  logic             cp,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] lim_din,
    input  logic             load_,
    input  logic             lim_ld_,
    input  logic             p,
    input  logic             t,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] lim,
    output logic             co,
    output logic             wrap
);

    logic             at_lim;
    logic             at_zero;
    logic             term;
    logic             count_en;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    // Terminal-state detection: up terminates at the limit, down terminates at zero.
    always_comb begin
        at_lim  = (q == lim);
        at_zero = (q == '0);
        term    = up ? at_lim : at_zero;
    end

    // Cascade output ignores p/load_/clr so a chain ripples on t alone.
    assign co = t && term;

    // Count steps only when not loading; plain modulo-2^WIDTH arithmetic lets a
    // value above the limit run on to all-ones and roll to 0 without a wrap.
    assign count_en = load_ && p && t;
    assign q_inc    = q + WIDTH'(1);
    assign q_dec    = q - WIDTH'(1);

    // Next counter value and wrap decision, always against the pre-edge limit.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (!load_) begin
            q_nxt = din;
        end else if (count_en) begin
`ifdef AM25LS_MODCNT_SAT_EN
            if (!term) begin
                q_nxt = up ? q_inc : q_dec;
            end
`else
            if (term) begin
                q_nxt    = up ? '0 : lim;
                wrap_nxt = 1'b1;
            end else begin
                q_nxt = up ? q_inc : q_dec;
            end
`endif
        end
    end

    // Counter and wrap registers; clr overrides every other control.
    always_ff @(posedge cp) begin
        if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

    // Limit register loads independently of the counter controls.
    always_ff @(posedge cp) begin
        if (clr) begin
            lim <= '1;
        end else if (!lim_ld_) begin
            lim <= lim_din;
        end
    end

endmodule

// File: tb/tb_am25ls_modcnt.sv
module tb_am25ls_modcnt;

    localparam int W = 4;

    logic         cp = 1'b0;
    logic         clr, load_, lim_ld_, p, t, up;
    logic [W-1:0] din, lim_din;
    logic [W-1:0] q, lim;
    logic         co, wrap;

    int nvec = 0;
    int nerr = 0;

    am25ls_modcnt #(.WIDTH(W)) dut (
        .cp(cp), .clr(clr), .din(din), .lim_din(lim_din),
        .load_(load_), .lim_ld_(lim_ld_), .p(p), .t(t), .up(up),
        .q(q), .lim(lim), .co(co), .wrap(wrap)
    );

    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; load_ = 1'b1; lim_ld_ = 1'b1; p = 1'b0; t = 1'b0; up = 1'b1;
        din = '0; lim_din = '0;
    endtask

    // Apply n counting edges with current controls; check q, wrap and co after each.
    task automatic run(input string tag, input int n, input int eq[8], input int ew[8], input int ec[8]);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s q[%0d]", tag, i), q, eq[i]);
            chk($sformatf("%s wrap[%0d]", tag, i), wrap, ew[i]);
            chk($sformatf("%s co[%0d]", tag, i), co, ec[i]);
        end
    endtask

    initial begin
        idle();
        clr = 1'b1;
        step();
        chk("rst q", q, 0);
        chk("rst lim", lim, 15);
        chk("rst wrap", wrap, 0);
        chk("rst co t=0", co, 0);

        // Load limit 5 without counting
        idle();
        lim_ld_ = 1'b0; lim_din = 4'd5;
        step();
        chk("limld lim", lim, 5);
        chk("limld q", q, 0);

`ifndef AM25LS_MODCNT_SAT_EN
        // Up count 0..5 then wrap to 0
        idle();
        p = 1'b1; t = 1'b1; up = 1'b1;
        #1 chk("up0 co", co, 0);
        run("up", 7, '{1,2,3,4,5,0,1,0}, '{0,0,0,0,0,1,0,0}, '{0,0,0,0,1,0,0,0});

        // Load 3 then count down through 0 -> lim
        load_ = 1'b0; din = 4'd3; up = 1'b0;
        step();
        chk("dnld q", q, 3);
        chk("dnld wrap", wrap, 0);
        load_ = 1'b1;
        run("dn", 5, '{2,1,0,5,4,0,0,0}, '{0,0,0,1,0,0,0,0}, '{0,0,1,0,0,0,0,0});

        // Count edge at q==lim uses old lim while lim is reloaded
        load_ = 1'b0; din = 4'd5; up = 1'b1;
        step();
        load_ = 1'b1; lim_ld_ = 1'b0; lim_din = 4'd9;
        step();
        chk("oldlim q", q, 0);
        chk("oldlim wrap", wrap, 1);
        chk("oldlim lim", lim, 9);
        lim_ld_ = 1'b1;

        // lim = 0: wraps every enabled cycle in both directions
        idle();
        lim_ld_ = 1'b0; lim_din = 4'd0; load_ = 1'b0; din = 4'd0;
        step();
        idle();
        p = 1'b1; t = 1'b1; up = 1'b1;
        run("lim0up", 2, '{0,0,0,0,0,0,0,0}, '{1,1,0,0,0,0,0,0}, '{1,1,0,0,0,0,0,0});
        up = 1'b0;
        run("lim0dn", 1, '{0,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0});
        lim_ld_ = 1'b0; lim_din = 4'd5;
        step();
        lim_ld_ = 1'b1;
`else
        // Saturating: from 4 up to lim 5, then hold
        idle();
        load_ = 1'b0; din = 4'd4;
        step();
        load_ = 1'b1; p = 1'b1; t = 1'b1; up = 1'b1;
        run("sat", 3, '{5,5,5,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{1,1,1,0,0,0,0,0});
`endif

        // q above lim: natural overflow, no wrap, co stays 0
        idle();
        load_ = 1'b0; din = 4'd12; p = 1'b1; t = 1'b1; up = 1'b1;
        step();
        chk("hi ld q", q, 12);
        load_ = 1'b1;
        run("hi", 5, '{13,14,15,0,1,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});

        // Same-edge counter + limit load, then p=1 t=0 holds
        idle();
        load_ = 1'b0; din = 4'd4;
        step();
        load_ = 1'b0; din = 4'd9; lim_ld_ = 1'b0; lim_din = 4'd2; p = 1'b1; t = 1'b1;
        step();
        chk("same q", q, 9);
        chk("same lim", lim, 2);
        idle();
        p = 1'b1; t = 1'b0; up = 1'b1;
        step();
        chk("hold q", q, 9);
        chk("hold co", co, 0);
        chk("hold wrap", wrap, 0);

        // Reset mid-count overrides load_ and lim_ld_
        idle();
        p = 1'b1; t = 1'b1; up = 1'b1;
        step();
        chk("pre-clr q", q, 10);
        clr = 1'b1; load_ = 1'b0; din = 4'd7; lim_ld_ = 1'b0; lim_din = 4'd3;
        step();
        chk("clr q", q, 0);
        chk("clr lim", lim, 15);
        chk("clr wrap", wrap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
